// File: rtl/vector_norm_sequencer.sv
// Euclidean norm of a packed N-element unsigned vector: one shared squarer/accumulator
// pass over the elements, then an iterative restoring square root, valid/ready on both sides.
module vector_norm_sequencer #(
    parameter int N     = 4,
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*WIDTH-1:0]   vector,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     norm,
    output logic                 ovf,
    output logic                 busy
);

    localparam int ACC_W    = 2 * WIDTH + $clog2(N);
    localparam int SQ_ITERS = (ACC_W + 1) / 2;
    localparam int SQ_W     = 2 * SQ_ITERS;
    localparam int REM_W    = SQ_ITERS + 2;
    localparam int IDX_W    = $clog2(N);
    localparam int CNT_W    = $clog2(SQ_ITERS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SQRT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [N*WIDTH-1:0]    vec_q, vec_d;
    logic [SQ_W-1:0]       acc_q, acc_d;
    logic [SQ_ITERS-1:0]   root_q, root_d;
    logic [REM_W-1:0]      rem_q, rem_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic [WIDTH-1:0]      norm_q, norm_d;
    logic                  ovf_q, ovf_d;

    logic [WIDTH-1:0]      elem_s;
    logic [2*WIDTH-1:0]    elem_ext_s;
    logic [2*WIDTH-1:0]    sq_s;
    logic [REM_W-1:0]      rem_sh_s;
    logic [REM_W-1:0]      trial_s;
    logic                  ge_s;
    logic                  sat_s;

    assign elem_s     = vec_q[idx_q*WIDTH +: WIDTH];
    assign elem_ext_s = {{WIDTH{1'b0}}, elem_s};
    assign sq_s       = elem_ext_s * elem_ext_s;

    // The top two remainder bits are always zero before the shift, so truncation is lossless.
    assign rem_sh_s = REM_W'({rem_q, acc_q[SQ_W-1 -: 2]});
    assign trial_s  = {root_q, 2'b01};
    assign ge_s     = (rem_sh_s >= trial_s);
    assign sat_s    = |root_q[SQ_ITERS-1:WIDTH];

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign norm      = norm_q;
    assign ovf       = ovf_q;

    // Next-state and datapath control for the four-phase sequence.
    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        acc_d       = acc_q;
        root_d      = root_q;
        rem_d       = rem_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        norm_d      = norm_q;
        ovf_d       = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    vec_d   = vector;
                    acc_d   = {SQ_W{1'b0}};
                    idx_d   = {IDX_W{1'b0}};
                    state_d = ACCUM;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCUM: begin
                acc_d = acc_q + SQ_W'(sq_s);
                if (idx_q == IDX_W'(N - 1)) begin
                    root_d  = {SQ_ITERS{1'b0}};
                    rem_d   = {REM_W{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = SQRT;
                end else begin
                    idx_d = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                end
            end
            SQRT: begin
                // One extra cycle after the last digit registers the saturated result.
                if (cnt_q == CNT_W'(SQ_ITERS)) begin
                    norm_d      = sat_s ? {WIDTH{1'b1}} : root_q[WIDTH-1:0];
                    ovf_d       = sat_s;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    rem_d  = ge_s ? (rem_sh_s - trial_s) : rem_sh_s;
                    root_d = {root_q[SQ_ITERS-2:0], ge_s};
                    acc_d  = {acc_q[SQ_W-3:0], 2'b00};
                    cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            vec_q       <= {(N*WIDTH){1'b0}};
            acc_q       <= {SQ_W{1'b0}};
            root_q      <= {SQ_ITERS{1'b0}};
            rem_q       <= {REM_W{1'b0}};
            idx_q       <= {IDX_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            out_valid_q <= 1'b0;
            norm_q      <= {WIDTH{1'b0}};
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            acc_q       <= acc_d;
            root_q      <= root_d;
            rem_q       <= rem_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            norm_q      <= norm_d;
            ovf_q       <= ovf_d;
        end
    end

endmodule

// File: tb/tb_vector_norm_sequencer.sv
// Directed table-driven bench for vector_norm_sequencer (N=4, WIDTH=16, latency 22).
module tb_vector_norm_sequencer;

    localparam int N   = 4;
    localparam int W   = 16;
    localparam int VW  = N * W;
    localparam int LAT = 22;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [VW-1:0] vector = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  norm;
    logic          ovf;
    logic          busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [VW-1:0] vec;
        logic [W-1:0]  exp_norm;
        logic          exp_ovf;
    } vec_rec_t;

    vector_norm_sequencer #(.N(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .vector    (vector),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .norm      (norm),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [VW-1:0] pack4(input logic [W-1:0] e0, e1, e2, e3);
        return {e3, e2, e1, e0};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Presents v and returns #1 after the accept edge.
    task automatic accept(input logic [VW-1:0] v);
        int k;
        k = 0;
        @(negedge clk);
        vector   = v;
        in_valid = 1'b1;
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("accept_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts edges from the accept edge until out_valid is seen.
    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    vec_rec_t tbl [12];
    int       lat;

    initial begin
        tbl[0]  = '{pack4(16'd3, 16'd4, 16'd0, 16'd0),             16'd5,      1'b0};
        tbl[1]  = '{pack4(16'd1, 16'd1, 16'd1, 16'd1),             16'd2,      1'b0};
        tbl[2]  = '{pack4(16'd1, 16'd1, 16'd0, 16'd0),             16'd1,      1'b0};
        tbl[3]  = '{pack4(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), 16'hFFFF,   1'b1};
        tbl[4]  = '{pack4(16'd0, 16'd0, 16'd0, 16'd0),             16'd0,      1'b0};
        tbl[5]  = '{pack4(16'd1, 16'd2, 16'd2, 16'd0),             16'd3,      1'b0};
        tbl[6]  = '{pack4(16'd2, 16'd3, 16'd5, 16'd7),             16'd9,      1'b0};
        tbl[7]  = '{pack4(16'd100, 16'd0, 16'd0, 16'd0),           16'd100,    1'b0};
        tbl[8]  = '{pack4(16'hFFFF, 16'd0, 16'd0, 16'd0),          16'hFFFF,   1'b0};
        tbl[9]  = '{pack4(16'hFFFF, 16'd1, 16'd0, 16'd0),          16'hFFFF,   1'b0};
        tbl[10] = '{pack4(16'hFFFF, 16'hFFFF, 16'd0, 16'd0),       16'hFFFF,   1'b1};
        tbl[11] = '{pack4(16'd0, 16'd0, 16'd6, 16'd8),             16'd10,     1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_norm",      {48'd0, norm},      64'd0);
        chk("rst_ovf",       {63'd0, ovf},       64'd0);
        chk("rst_busy",      {63'd0, busy},      64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table of single transfers with out_ready held high
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            accept(tbl[i].vec);
            chk("tbl_ready_drop", {63'd0, in_ready}, 64'd0);
            chk("tbl_busy",       {63'd0, busy},     64'd1);
            wait_out(lat);
            chk("tbl_latency",    64'(lat),          64'(LAT));
            chk("tbl_norm",       {48'd0, norm},     {48'd0, tbl[i].exp_norm});
            chk("tbl_ovf",        {63'd0, ovf},      {63'd0, tbl[i].exp_ovf});
            @(posedge clk);
            #1;
            chk("tbl_done_valid", {63'd0, out_valid}, 64'd0);
            chk("tbl_idle_ready", {63'd0, in_ready},  64'd1);
            chk("tbl_norm_hold",  {48'd0, norm},      {48'd0, tbl[i].exp_norm});
        end

        // Backpressure: result held, in_valid ignored, no accept on the completing edge
        out_ready = 1'b0;
        accept(pack4(16'd0, 16'd0, 16'd6, 16'd8));
        wait_out(lat);
        chk("bp_latency", 64'(lat),      64'(LAT));
        chk("bp_norm",    {48'd0, norm}, 64'd10);
        for (int c = 0; c < 10; c++) begin
            in_valid = c[0];
            vector   = pack4(16'd20, 16'd0, 16'd0, 16'd0);
            @(posedge clk);
            #1;
            chk("bp_hold_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_hold_norm",  {48'd0, norm},      64'd10);
            chk("bp_no_accept",  {63'd0, in_ready},  64'd0);
        end
        in_valid  = 1'b1;
        vector    = pack4(16'd7, 16'd0, 16'd0, 16'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_xfer_valid",  {63'd0, out_valid}, 64'd0);
        chk("bp_xfer_nobusy", {63'd0, busy},      64'd0);
        chk("bp_xfer_norm",   {48'd0, norm},      64'd10);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_next_busy", {63'd0, busy}, 64'd1);
        wait_out(lat);
        chk("bp_next_latency", 64'(lat),      64'(LAT));
        chk("bp_next_norm",    {48'd0, norm}, 64'd7);
        @(posedge clk);
        #1;

        // Input changes after accept have no effect
        accept(pack4(16'd5, 16'd12, 16'd0, 16'd0));
        vector = {VW{1'b1}};
        wait_out(lat);
        vector = '0;
        chk("stab_latency", 64'(lat),      64'(LAT));
        chk("stab_norm",    {48'd0, norm}, 64'd13);
        chk("stab_ovf",     {63'd0, ovf},  64'd0);
        @(posedge clk);
        #1;

        // Reset on SQRT cycle 10 aborts the operation
        accept(pack4(16'd30, 16'd40, 16'd0, 16'd0));
        repeat (N + 9) @(posedge clk);
        #1;
        chk("abort_pre_busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        #1;
        chk("abort_valid", {63'd0, out_valid}, 64'd0);
        chk("abort_norm",  {48'd0, norm},      64'd0);
        chk("abort_ready", {63'd0, in_ready},  64'd1);
        chk("abort_busy",  {63'd0, busy},      64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        begin
            int seen;
            seen = 0;
            repeat (30) begin
                @(posedge clk);
                #1;
                if (out_valid) seen++;
            end
            chk("abort_no_output", 64'(seen), 64'd0);
        end
        accept(pack4(16'd0, 16'd0, 16'd0, 16'd9));
        wait_out(lat);
        chk("post_abort_latency", 64'(lat),      64'(LAT));
        chk("post_abort_norm",    {48'd0, norm}, 64'd9);
        chk("post_abort_ovf",     {63'd0, ovf},  64'd0);
        @(posedge clk);
        #1;
        chk("post_abort_idle", {63'd0, in_ready}, 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vector_norm_sequencer.md
Name: vector_norm_sequencer

Overview:
- Multi-cycle controller that turns a packed N-element vector into its Euclidean norm, floor(sqrt(sum of x_i^2)).
- Sequences one shared squarer/accumulator over the N elements, then an iterative restoring integer square root, using valid/ready handshakes on both sides.
- Sits in front of the Gohub-Kahan normalization path and supplies the vector norm used to scale vectors.

Parameters:
- N, 4, number of vector elements (>=2)
- WIDTH, 16, bits per unsigned element and per norm output
- ACC_W, 2*WIDTH+$clog2(N), accumulator width (derived, localparam)
- SQ_ITERS, (ACC_W+1)/2, square-root iterations (derived, localparam)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  vector present on `vector`
- in_ready  output  1  block can accept a vector
- vector  input  N*WIDTH  element i at vector[i*WIDTH +: WIDTH], unsigned
- out_valid  output  1  norm/ovf valid
- out_ready  input  1  consumer accepts result
- norm  output  WIDTH  floor(sqrt(sum of squares)), saturated
- ovf  output  1  true root exceeded 2^WIDTH-1
- busy  output  1  state != IDLE

Behaviour:
- Reset (asynchronous, any state): state=IDLE; in_ready=1; out_valid=0; norm=0; ovf=0; busy=0; accumulator, root, remainder, element index=0.
- FSM states: IDLE, ACCUM, SQRT, DONE.
- IDLE: in_ready=1. On the edge where in_valid&&in_ready, latch the full vector, clear the accumulator, set idx=0 and go to ACCUM.
- ACCUM: one element per cycle, acc += x[idx]*x[idx] at full ACC_W width (no overflow possible). Runs for exactly N cycles (idx 0..N-1), then goes to SQRT with root=0 and remainder=0.
- SQRT: restoring digit-by-digit square root. Each cycle consumes 2 MSBs of acc, MSB first; acc is zero-extended to 2*SQ_ITERS bits. Runs for exactly SQ_ITERS cycles, then goes to DONE.
- Entering DONE:
  - If root > 2^WIDTH-1: norm=2^WIDTH-1, ovf=1.
  - Else: norm=root[WIDTH-1:0], ovf=0.
  - out_valid=1.
- Latency: out_valid is first seen high N+SQ_ITERS+1 edges after the accept edge. Default N=4, WIDTH=16: SQ_ITERS=17, latency 22.
- DONE:
  - out_valid, norm and ovf are held stable until out_valid&&out_ready.
  - On that edge, out_valid drops and state returns to IDLE.
  - norm and ovf keep their last value until the next DONE.
- in_ready=1 only in IDLE. No new vector can be accepted in the cycle out_valid&&out_ready completes; the earliest acceptance is the following cycle.
- in_valid outside IDLE is ignored. `vector` is sampled only on the accept edge, so later changes to the input have no effect.
- out_ready in states other than DONE is ignored.
- All-zero vector: norm=0, ovf=0, same latency.
- Reset asserted mid-ACCUM or mid-SQRT aborts the operation. No out_valid is produced for the aborted vector.

Test Plan:
- Reset, then vector {3,4,0,0} with out_ready=1: in_ready drops the cycle after accept; out_valid high exactly 22 cycles after the accept edge with norm=5, ovf=0; back to IDLE one cycle later.
- Back-to-back vectors {1,1,1,1} then {1,1,0,0}: norm=2, then norm=1 (floor of sqrt 2). The second vector is accepted only once in_ready returns high.
- All elements 0xFFFF: sum=17179344900, true root 131070 -> norm=0xFFFF, ovf=1.
- Backpressure: {0,0,6,8}, out_ready=0 for 10 cycles after out_valid -> norm=10 held stable with out_valid high; a pulse on in_valid in that window is not accepted; raising out_ready completes the transfer in one cycle.
- Input stability: accept {5,12,0,0}, then change `vector` to all-ones during ACCUM -> norm=13.
- Reset pulsed on cycle 10 of SQRT -> immediate IDLE, out_valid=0, norm=0. The next vector {0,0,0,9} yields norm=9 with normal latency.
